// File: rtl/playfield_pkg.sv
// Shared cell codes, FSM states and the attack table
// for the playfield line-resolution engine.
package playfield_pkg;

   typedef enum logic [3:0] {
      NON   = 4'd0,
      PC_I  = 4'd1,
      PC_O  = 4'd2,
      PC_T  = 4'd3,
      PC_S  = 4'd4,
      PC_Z  = 4'd5,
      PC_J  = 4'd6,
      PC_L  = 4'd7,
      TRASH = 4'd8
   } cell_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLACE,
      S_SCAN,
      S_COMPACT,
      S_CANCEL,
      S_GARB,
      S_DONE
   } state_e;

   // Rows sent to the opponent for a given number of cleared rows.
   function automatic logic [4:0] attack_tbl(input logic [2:0] l);
      logic [4:0] a;
      unique case (l)
         3'd0, 3'd1: a = 5'd0;
         3'd2:       a = 5'd1;
         3'd3:       a = 5'd2;
         default:    a = 5'd4;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/playfield_engine_garbage_queue.sv
// Pending-garbage counter: cancel or subtract first,
// then add the incoming strobe and saturate.
module garbage_queue
   import playfield_pkg::*;
#(
   parameter int COLS     = 10,
   parameter int GARB_MAX = 15,
   parameter int XW       = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          add_valid_i,
   input  logic [4:0]    add_lines_i,
   input  logic [XW-1:0] hole_i,
   input  logic          cancel_i,
   input  logic [4:0]    sent_i,
   input  logic          sub_i,
   input  logic [4:0]    sub_lines_i,
   output logic [4:0]    pending_o,
   output logic [4:0]    pend_cancel_o,
   output logic [4:0]    attack_o,
   output logic [XW-1:0] hole_o
);

   logic [4:0]    p_q, p_d, p_mid;
   logic [5:0]    sum;
   logic [XW-1:0] hole_q, hole_clamp;

   // Cancel/subtract, then add, then saturate.
   always_comb begin
      p_mid    = p_q;
      attack_o = '0;
      if (cancel_i) begin
         if (sent_i >= p_q) begin
            attack_o = sent_i - p_q;
            p_mid    = '0;
         end else begin
            p_mid = p_q - sent_i;
         end
      end else if (sub_i) begin
         p_mid = (p_q >= sub_lines_i) ? p_q - sub_lines_i : '0;
      end
      sum = {1'b0, p_mid};
      if (add_valid_i) sum = sum + {1'b0, add_lines_i};
      p_d = (int'(sum) > GARB_MAX) ? 5'(GARB_MAX) : sum[4:0];
   end

   assign hole_clamp = (int'(hole_i) >= COLS) ? XW'(COLS - 1) : hole_i;

   // Counter and hole-column registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q    <= '0;
         hole_q <= '0;
      end else if (clear_i) begin
         p_q    <= '0;
         hole_q <= '0;
      end else begin
         p_q <= p_d;
         if (add_valid_i) hole_q <= hole_clamp;
      end
   end

   assign pending_o     = p_q;
   assign pend_cancel_o = p_mid;
   assign hole_o        = hole_q;

endmodule

// File: rtl/playfield_engine.sv
// Playfield store: piece write, row clear/compact,
// attack cancellation and garbage row insertion.
module playfield_engine
   import playfield_pkg::*;
#(
   parameter int COLS     = 10,
   parameter int ROWS     = 20,
   parameter int CELL_W   = 4,
   parameter int GARB_MAX = 15,
   parameter int XW       = $clog2(COLS),
   parameter int YW       = $clog2(ROWS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     place_valid,
   output logic                     place_ready,
   input  logic [CELL_W-1:0]        place_type,
   input  logic [4*(XW+YW)-1:0]     place_cells,
   input  logic                     garb_add_valid,
   input  logic [4:0]               garb_add_lines,
   input  logic [XW-1:0]            garb_hole,
   output logic                     done,
   output logic [2:0]               lines_cleared,
   output logic [4:0]               attack_lines,
   output logic [4:0]               pending_garb,
   output logic                     top_out,
   input  logic [XW-1:0]            rd_x,
   input  logic [YW-1:0]            rd_y,
   output logic [CELL_W-1:0]        rd_cell,
   output logic [ROWS*COLS-1:0]     occupied
);

   localparam int PW = XW + YW;

   typedef logic [COLS-1:0][CELL_W-1:0] row_t;

   state_e         state_q, state_d;
   row_t           board_q [ROWS];
   logic [4*PW-1:0] cells_q;
   logic [CELL_W-1:0] type_q;
   logic [ROWS-1:0] full_q, row_full;
   logic [2:0]     lcnt_q, lcnt_d;
   logic [YW-1:0]  r_q, src_idx;
   logic [YW:0]    s_q, g_q, g_new, garb_src, cnt;
   logic           top_q, src_found, top_hit;
   logic [2:0]     lines_q;
   logic [4:0]     attack_q, att_q, attack_w, pend_cancel;
   logic [XW-1:0]  hole;
   logic [XW-1:0]  px [4];
   logic [YW-1:0]  py [4];
   logic [3:0]     pen;
   row_t           trash_row;

   garbage_queue #(
      .COLS     (COLS),
      .GARB_MAX (GARB_MAX),
      .XW       (XW)
   ) u_gq (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear_i),
      .add_valid_i   (garb_add_valid),
      .add_lines_i   (garb_add_lines),
      .hole_i        (garb_hole),
      .cancel_i      (state_q == S_CANCEL),
      .sent_i        (attack_tbl(lcnt_q)),
      .sub_i         (state_q == S_GARB && int'(r_q) == ROWS - 1),
      .sub_lines_i   (5'(g_q)),
      .pending_o     (pending_garb),
      .pend_cancel_o (pend_cancel),
      .attack_o      (attack_w),
      .hole_o        (hole)
   );

   // Unpack the four placement cells and flag in-range ones.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         px[k]  = cells_q[(3-k)*PW+YW +: XW];
         py[k]  = cells_q[(3-k)*PW +: YW];
         pen[k] = (int'(px[k]) < COLS) && (int'(py[k]) < ROWS);
      end
   end

   // Full-row mask and its clamped popcount.
   always_comb begin
      cnt = '0;
      for (int r = 0; r < ROWS; r++) begin
         row_full[r] = 1'b1;
         for (int c = 0; c < COLS; c++)
            if (board_q[r][c] == '0) row_full[r] = 1'b0;
         cnt = cnt + (YW+1)'(row_full[r]);
      end
      lcnt_d = (int'(cnt) > 4) ? 3'd4 : cnt[2:0];
   end

   // Compaction source: lowest non-full row above the pointer.
   always_comb begin
      src_found = 1'b0;
      src_idx   = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (!full_q[i] && (YW+1)'(i) < s_q) begin
            src_found = 1'b1;
            src_idx   = YW'(i);
         end
      end
   end

   // Garbage depth, top-out probe and the inserted trash row.
   always_comb begin
      g_new   = (int'(pend_cancel) > ROWS) ? (YW+1)'(ROWS)
                                            : (YW+1)'(pend_cancel);
      top_hit = 1'b0;
      for (int r = 0; r < ROWS; r++)
         if ((YW+1)'(r) < g_new && board_q[r] != '0) top_hit = 1'b1;
      for (int c = 0; c < COLS; c++)
         trash_row[c] = (XW'(c) == hole) ? '0 : CELL_W'(TRASH);
      garb_src = {1'b0, r_q} + g_q;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (place_valid) state_d = S_PLACE;
         S_PLACE:   state_d = S_SCAN;
         S_SCAN:    state_d = S_COMPACT;
         S_COMPACT: if (r_q == '0) state_d = S_CANCEL;
         S_CANCEL:  state_d = (lcnt_q != '0 || pend_cancel == '0)
                              ? S_DONE : S_GARB;
         S_GARB:    if (int'(r_q) == ROWS - 1) state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         state_q <= S_IDLE;
      else if (clear_i) state_q <= S_IDLE;
      else              state_q <= state_d;
   end

   // Board and resolution datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         board_q  <= '{default: '0};
         cells_q  <= '0;
         type_q   <= '0;
         full_q   <= '0;
         lcnt_q   <= '0;
         r_q      <= '0;
         s_q      <= '0;
         g_q      <= '0;
         top_q    <= 1'b0;
         lines_q  <= '0;
         attack_q <= '0;
         att_q    <= '0;
      end else if (clear_i) begin
         board_q  <= '{default: '0};
         full_q   <= '0;
         lcnt_q   <= '0;
         r_q      <= '0;
         s_q      <= '0;
         g_q      <= '0;
         top_q    <= 1'b0;
         lines_q  <= '0;
         attack_q <= '0;
         att_q    <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (place_valid) begin
                  cells_q <= place_cells;
                  type_q  <= place_type;
               end
            end
            S_PLACE: begin
               for (int k = 0; k < 4; k++) begin
                  if (pen[k]) begin
                     board_q[py[k]][px[k]] <= type_q;
                     if (board_q[py[k]][px[k]] != '0) top_q <= 1'b1;
                  end
               end
            end
            S_SCAN: begin
               full_q <= row_full;
               lcnt_q <= lcnt_d;
               r_q    <= YW'(ROWS - 1);
               s_q    <= (YW+1)'(ROWS);
            end
            S_COMPACT: begin
               board_q[r_q] <= src_found ? board_q[src_idx] : '0;
               s_q <= src_found ? {1'b0, src_idx} : '0;
               r_q <= r_q - 1'b1;
            end
            S_CANCEL: begin
               att_q <= attack_w;
               g_q   <= g_new;
               r_q   <= '0;
               if (state_d == S_GARB && top_hit) top_q <= 1'b1;
            end
            S_GARB: begin
               board_q[r_q] <= (int'(garb_src) < ROWS)
                               ? board_q[garb_src[YW-1:0]] : trash_row;
               r_q <= r_q + 1'b1;
            end
            default: ;
         endcase
         if (state_d == S_DONE && state_q != S_DONE) begin
            lines_q  <= lcnt_q;
            attack_q <= (state_q == S_CANCEL) ? attack_w : att_q;
         end
      end
   end

   // Read port and occupancy map.
   always_comb begin
      rd_cell = '0;
      if (int'(rd_x) < COLS && int'(rd_y) < ROWS)
         rd_cell = board_q[rd_y][rd_x];
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            occupied[r*COLS+c] = |board_q[r][c];
   end

   assign place_ready   = (state_q == S_IDLE);
   assign done          = (state_q == S_DONE);
   assign lines_cleared = lines_q;
   assign attack_lines  = attack_q;
   assign top_out       = top_q;

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine: placement,
// clears, cancellation, garbage and top-out.
module tb_playfield_engine;

   localparam int XW = 4;
   localparam int YW = 5;
   localparam int PW = XW + YW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clear_i = 1'b0;
   logic          place_valid = 1'b0;
   logic          place_ready;
   logic [3:0]    place_type = '0;
   logic [4*PW-1:0] place_cells = '0;
   logic          garb_add_valid = 1'b0;
   logic [4:0]    garb_add_lines = '0;
   logic [XW-1:0] garb_hole = '0;
   logic          done;
   logic [2:0]    lines_cleared;
   logic [4:0]    attack_lines;
   logic [4:0]    pending_garb;
   logic          top_out;
   logic [XW-1:0] rd_x = '0;
   logic [YW-1:0] rd_y = '0;
   logic [3:0]    rd_cell;
   logic [199:0]  occupied;

   int checks = 0;
   int errors = 0;

   playfield_engine dut (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (clear_i),
      .place_valid    (place_valid),
      .place_ready    (place_ready),
      .place_type     (place_type),
      .place_cells    (place_cells),
      .garb_add_valid (garb_add_valid),
      .garb_add_lines (garb_add_lines),
      .garb_hole      (garb_hole),
      .done           (done),
      .lines_cleared  (lines_cleared),
      .attack_lines   (attack_lines),
      .pending_garb   (pending_garb),
      .top_out        (top_out),
      .rd_x           (rd_x),
      .rd_y           (rd_y),
      .rd_cell        (rd_cell),
      .occupied       (occupied)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] pc(input int x, input int y);
      return {4'(x), 5'(y)};
   endfunction

   // Place a piece, measure accept-to-done latency, return in IDLE.
   task automatic place(input logic [4*PW-1:0] cl, input logic [3:0] ty,
                        input int exp_lat, input string nm);
      int lat;
      bit got;
      got = 0;
      lat = 0;
      @(negedge clk);
      checks++;
      if (place_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", nm, place_ready);
      end
      place_cells = cl;
      place_type  = ty;
      place_valid = 1'b1;
      @(posedge clk);
      #1;
      place_valid = 1'b0;
      checks++;
      if (place_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s busy: got %b want 0", nm, place_ready);
      end
      for (int k = 1; k <= 200 && !got; k++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            got = 1;
            lat = k + 1;
         end
      end
      checks++;
      if (!got || lat != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic garb_add(input logic [4:0] n, input logic [XW-1:0] h);
      @(negedge clk);
      garb_add_lines = n;
      garb_hole      = h;
      garb_add_valid = 1'b1;
      @(negedge clk);
      garb_add_valid = 1'b0;
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (place_ready !== 1'b1 || done !== 1'b0 || top_out !== 1'b0) begin
         errors++;
         $display("FAIL reset ctl: got rdy=%b done=%b top=%b want 1 0 0",
                  place_ready, done, top_out);
      end
      checks++;
      if (pending_garb !== 5'd0 || lines_cleared !== 3'd0 ||
          attack_lines !== 5'd0 || occupied !== '0) begin
         errors++;
         $display("FAIL reset state: got p=%0d l=%0d a=%0d occ=%h want 0",
                  pending_garb, lines_cleared, attack_lines, occupied);
      end
   endtask

   task automatic test_single();
      logic [199:0] exp;
      exp = '0;
      for (int c = 0; c < 4; c++) exp[190+c] = 1'b1;
      place({pc(0,19), pc(1,19), pc(2,19), pc(3,19)}, 4'd1, 24, "single");
      checks++;
      if (lines_cleared !== 3'd0 || attack_lines !== 5'd0) begin
         errors++;
         $display("FAIL single result: got l=%0d a=%0d want 0 0",
                  lines_cleared, attack_lines);
      end
      checks++;
      if (occupied !== exp) begin
         errors++;
         $display("FAIL single occ: got %h want %h", occupied, exp);
      end
      rd_x = 4'd3; rd_y = 5'd19; #1;
      checks++;
      if (rd_cell !== 4'd1) begin
         errors++;
         $display("FAIL single rd: got %0d want 1", rd_cell);
      end
      rd_x = 4'd12; rd_y = 5'd19; #1;
      checks++;
      if (rd_cell !== 4'd0) begin
         errors++;
         $display("FAIL rd range: got %0d want 0", rd_cell);
      end
   endtask

   task automatic test_single_clear();
      logic [199:0] exp;
      exp = '0;
      exp[190] = 1'b1;
      exp[199] = 1'b1;
      place({pc(4,19), pc(5,19), pc(0,18), pc(9,18)}, 4'd2, 24, "prefill");
      place({pc(6,19), pc(7,19), pc(8,19), pc(9,19)}, 4'd1, 24, "clear1");
      checks++;
      if (lines_cleared !== 3'd1 || attack_lines !== 5'd0) begin
         errors++;
         $display("FAIL clear1 result: got l=%0d a=%0d want 1 0",
                  lines_cleared, attack_lines);
      end
      checks++;
      if (occupied !== exp) begin
         errors++;
         $display("FAIL clear1 occ: got %h want %h", occupied, exp);
      end
      rd_x = 4'd9; rd_y = 5'd19; #1;
      checks++;
      if (rd_cell !== 4'd2) begin
         errors++;
         $display("FAIL clear1 rd: got %0d want 2", rd_cell);
      end
   endtask

   task automatic test_clear();
      do_clear();
      checks++;
      if (occupied !== '0 || place_ready !== 1'b1 || lines_cleared !== 3'd0) begin
         errors++;
         $display("FAIL clear: got occ=%h rdy=%b l=%0d want 0 1 0",
                  occupied, place_ready, lines_cleared);
      end
   endtask

   task automatic test_tetris();
      logic [4*PW-1:0] cl;
      int k;
      for (int j = 0; j < 9; j++) begin
         cl = '0;
         for (int i = 0; i < 4; i++) begin
            k = 4*j + i;
            cl[(3-i)*PW +: PW] = pc(k % 9, 16 + k / 9);
         end
         place(cl, 4'(1 + j % 7), 24, "stack");
      end
      garb_add(5'd1, 4'd0);
      checks++;
      if (pending_garb !== 5'd1) begin
         errors++;
         $display("FAIL tetris pend pre: got %0d want 1", pending_garb);
      end
      place({pc(9,16), pc(9,17), pc(9,18), pc(9,19)}, 4'd1, 24, "tetris");
      checks++;
      if (lines_cleared !== 3'd4 || attack_lines !== 5'd3 ||
          pending_garb !== 5'd0) begin
         errors++;
         $display("FAIL tetris: got l=%0d a=%0d p=%0d want 4 3 0",
                  lines_cleared, attack_lines, pending_garb);
      end
      checks++;
      if (occupied !== '0) begin
         errors++;
         $display("FAIL tetris occ: got %h want 0", occupied);
      end
   endtask

   task automatic test_garbage();
      logic [199:0] exp;
      exp = '0;
      for (int c = 0; c < 4; c++) exp[160+c] = 1'b1;
      for (int r = 17; r < 20; r++)
         for (int c = 0; c < 10; c++)
            if (c != 4) exp[r*10+c] = 1'b1;
      garb_add(5'd3, 4'd4);
      place({pc(0,19), pc(1,19), pc(2,19), pc(3,19)}, 4'd1, 44, "garb");
      checks++;
      if (lines_cleared !== 3'd0 || attack_lines !== 5'd0 ||
          pending_garb !== 5'd0 || top_out !== 1'b0) begin
         errors++;
         $display("FAIL garb: got l=%0d a=%0d p=%0d t=%b want 0 0 0 0",
                  lines_cleared, attack_lines, pending_garb, top_out);
      end
      checks++;
      if (occupied !== exp) begin
         errors++;
         $display("FAIL garb occ: got %h want %h", occupied, exp);
      end
      rd_x = 4'd5; rd_y = 5'd18; #1;
      checks++;
      if (rd_cell !== 4'd8) begin
         errors++;
         $display("FAIL garb trash: got %0d want 8", rd_cell);
      end
   endtask

   task automatic test_saturate();
      garb_add(5'd12, 4'd0);
      checks++;
      if (pending_garb !== 5'd12) begin
         errors++;
         $display("FAIL sat1: got %0d want 12", pending_garb);
      end
      garb_add(5'd12, 4'd0);
      checks++;
      if (pending_garb !== 5'd15) begin
         errors++;
         $display("FAIL sat2: got %0d want 15", pending_garb);
      end
      do_clear();
      checks++;
      if (pending_garb !== 5'd0) begin
         errors++;
         $display("FAIL sat clr: got %0d want 0", pending_garb);
      end
   endtask

   task automatic test_overwrite();
      logic [199:0] exp;
      do_clear();
      exp = '0;
      exp[55] = 1'b1;
      place({pc(12,0), pc(0,25), pc(5,5), pc(5,5)}, 4'd3, 24, "range");
      checks++;
      if (occupied !== exp || top_out !== 1'b0) begin
         errors++;
         $display("FAIL range: got occ=%h t=%b want %h 0",
                  occupied, top_out, exp);
      end
      place({pc(5,5), pc(6,5), pc(7,5), pc(8,5)}, 4'd4, 24, "overwr");
      rd_x = 4'd5; rd_y = 5'd5; #1;
      checks++;
      if (top_out !== 1'b1 || rd_cell !== 4'd4) begin
         errors++;
         $display("FAIL overwr: got t=%b c=%0d want 1 4", top_out, rd_cell);
      end
   endtask

   task automatic test_topout();
      do_clear();
      place({pc(0,0), pc(1,0), pc(2,0), pc(3,0)}, 4'd3, 24, "row0");
      checks++;
      if (top_out !== 1'b0) begin
         errors++;
         $display("FAIL row0 top: got %b want 0", top_out);
      end
      garb_add(5'd2, 4'd13);
      place({pc(0,19), pc(1,19), pc(2,19), pc(3,19)}, 4'd1, 44, "topgarb");
      checks++;
      if (top_out !== 1'b1 || pending_garb !== 5'd0) begin
         errors++;
         $display("FAIL topgarb: got t=%b p=%0d want 1 0",
                  top_out, pending_garb);
      end
      rd_x = 4'd9; rd_y = 5'd19; #1;
      checks++;
      if (rd_cell !== 4'd0) begin
         errors++;
         $display("FAIL hole clamp: got %0d want 0", rd_cell);
      end
      rd_x = 4'd8; rd_y = 5'd18; #1;
      checks++;
      if (rd_cell !== 4'd8) begin
         errors++;
         $display("FAIL topgarb trash: got %0d want 8", rd_cell);
      end
      rd_x = 4'd0; rd_y = 5'd17; #1;
      checks++;
      if (rd_cell !== 4'd1) begin
         errors++;
         $display("FAIL topgarb shift: got %0d want 1", rd_cell);
      end
      do_clear();
      checks++;
      if (top_out !== 1'b0 || place_ready !== 1'b1 || occupied !== '0) begin
         errors++;
         $display("FAIL topclr: got t=%b r=%b occ=%h want 0 1 0",
                  top_out, place_ready, occupied);
      end
   endtask

   task automatic test_clear_mid();
      int seen;
      seen = 0;
      @(negedge clk);
      place_cells = {pc(0,19), pc(1,19), pc(2,19), pc(3,19)};
      place_type  = 4'd5;
      place_valid = 1'b1;
      @(negedge clk);
      place_valid = 1'b0;
      repeat (5) @(negedge clk);
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      checks++;
      if (place_ready !== 1'b1 || occupied !== '0) begin
         errors++;
         $display("FAIL midclr: got r=%b occ=%h want 1 0",
                  place_ready, occupied);
      end
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midclr done: got %0d pulses want 0", seen);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_single_clear();
      test_clear();
      test_tetris();
      test_garbage();
      test_saturate();
      test_overwrite();
      test_topout();
      test_clear_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
